img_frame_sequencer: RTL and testbench

Frame-timing controller that sequences the pixel-stream datapath. It generates the linear pixel read address, the line (HSYNC) and frame (VSYNC) envelopes, and programmable horizontal and vertical blanking. It honours downstream back-pressure, runs a programmed number of frames (or runs continuously), and latches the per-frame processing-operation select. It sits between the software/testbench control interface and the image read/processing datapath, which consumes rd_addr and the qualifiers.

---
 rtl/img_pkg.sv | 25 ++
 rtl/img_pos_counter.sv | 58 +++++
 rtl/img_frame_sequencer.sv | 170 +++++++++++++++++
 tb/tb_img_frame_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared definitions for the image frame pipeline: state encoding, operation codes, width helpers.
package img_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LINE   = 2'd1,
      ST_HBLANK = 2'd2,
      ST_VBLANK = 2'd3
   } state_t;

   localparam logic [1:0] OP_PASS   = 2'd0;
   localparam logic [1:0] OP_BRIGHT = 2'd1;
   localparam logic [1:0] OP_GRAY   = 2'd2;
   localparam logic [1:0] OP_THRESH = 2'd3;

   // Bits needed to index 0..n-1, never less than one.
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int addr_w(input int w, input int h);
      return idx_w(w * h);
   endfunction

endpackage

// File: rtl/img_pos_counter.sv
// Raster position tracker (col/row/linear address); updates one cycle after en, clr wins over en.
// No backpressure of its own: the owner gates en with its transfer handshake.
module img_pos_counter
   import img_pkg::*;
#(
   parameter int WIDTH  = 768,
   parameter int HEIGHT = 512,
   parameter int ADDR_W = 19,
   parameter int COL_W  = idx_w(WIDTH),
   parameter int ROW_W  = idx_w(HEIGHT)
)(
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              clr,
   input  logic              en,
   output logic [COL_W-1:0]  col,
   output logic [ROW_W-1:0]  row,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              col_last,
   output logic              frame_last
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

   logic row_last;

   assign col_last   = (col == COL_LAST);
   assign row_last   = (row == ROW_LAST);
   assign frame_last = col_last && row_last;

   // The address is a running count, so no row*WIDTH product is ever formed.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         col     <= '0;
         row     <= '0;
         rd_addr <= '0;
      end else if (clr) begin
         col     <= '0;
         row     <= '0;
         rd_addr <= '0;
      end else if (en) begin
         if (frame_last) begin
            col     <= '0;
            row     <= '0;
            rd_addr <= '0;
         end else if (col_last) begin
            col     <= '0;
            row     <= row + 1'b1;
            rd_addr <= rd_addr + 1'b1;
         end else begin
            col     <= col + 1'b1;
            rd_addr <= rd_addr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/img_frame_sequencer.sv
// Frame timing controller: pixel address, HSYNC/VSYNC envelopes and blanking; first pixel one cycle after start.
// out_ready low freezes position and qualifiers in LINE; blanking counters run regardless.
module img_frame_sequencer
   import img_pkg::*;
#(
   parameter int WIDTH  = 768,
   parameter int HEIGHT = 512,
   parameter int HBLANK = 16,
   parameter int VBLANK = 64,
   parameter int ADDR_W = 19
)(
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              start,
   input  logic              abort,
   input  logic [7:0]        num_frames,
   input  logic [1:0]        op_sel_in,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              pix_valid,
   output logic              HSYNC,
   output logic              VSYNC,
   output logic              sof,
   output logic              eol,
   output logic              eof,
   output logic [1:0]        op_sel,
   output logic              busy,
   output logic              frame_done,
   output logic [7:0]        frame_cnt
);

   localparam int COL_W = idx_w(WIDTH);
   localparam int ROW_W = idx_w(HEIGHT);
   localparam int BMAX  = (HBLANK > VBLANK) ? HBLANK : VBLANK;
   localparam int BW    = idx_w(BMAX);
   localparam logic [BW-1:0] HB_LAST = BW'((HBLANK > 0) ? HBLANK - 1 : 0);
   localparam logic [BW-1:0] VB_LAST = BW'((VBLANK > 0) ? VBLANK - 1 : 0);

   state_t            state, state_nxt;
   logic [BW-1:0]     blank_cnt, blank_cnt_nxt;
   logic [7:0]        num_frames_q;
   logic [7:0]        frame_cnt_inc;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic              col_last, frame_last;
   logic              pos_en, pos_clr, op_ld, run_ld, frame_inc, done_nxt;

   img_pos_counter #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .ADDR_W (ADDR_W),
      .COL_W  (COL_W),
      .ROW_W  (ROW_W)
   ) u_pos (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .clr        (pos_clr),
      .en         (pos_en),
      .col        (col),
      .row        (row),
      .rd_addr    (rd_addr),
      .col_last   (col_last),
      .frame_last (frame_last)
   );

   // Qualifiers come from registered state only, so out_ready never reaches them.
   assign pix_valid     = (state == ST_LINE);
   assign HSYNC         = pix_valid;
   assign VSYNC         = (state == ST_LINE) || (state == ST_HBLANK);
   assign busy          = (state != ST_IDLE);
   assign sof           = pix_valid && (col == '0) && (row == '0);
   assign eol           = pix_valid && col_last;
   assign eof           = pix_valid && frame_last;
   assign frame_cnt_inc = frame_cnt + 8'd1;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state        <= ST_IDLE;
         blank_cnt    <= '0;
         num_frames_q <= '0;
         frame_cnt    <= '0;
         op_sel       <= '0;
         frame_done   <= 1'b0;
      end else begin
         state      <= state_nxt;
         blank_cnt  <= blank_cnt_nxt;
         frame_done <= done_nxt;
         if (run_ld) begin
            num_frames_q <= num_frames;
            frame_cnt    <= '0;
         end else if (frame_inc) begin
            frame_cnt <= frame_cnt_inc;
         end
         if (op_ld)
            op_sel <= op_sel_in;
      end
   end

   always_comb begin
      state_nxt     = state;
      blank_cnt_nxt = blank_cnt;
      pos_en        = 1'b0;
      pos_clr       = 1'b0;
      op_ld         = 1'b0;
      run_ld        = 1'b0;
      frame_inc     = 1'b0;
      done_nxt      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_LINE;
               pos_clr   = 1'b1;
               op_ld     = 1'b1;
               run_ld    = 1'b1;
            end
         end
         ST_LINE: begin
            if (out_ready) begin
               pos_en = 1'b1;
               if (frame_last) begin
                  frame_inc = 1'b1;
                  done_nxt  = 1'b1;
                  if ((num_frames_q != 8'd0) && (frame_cnt_inc == num_frames_q)) begin
                     state_nxt = ST_IDLE;
                  end else if (VBLANK == 0) begin
                     op_ld   = 1'b1;
                     pos_clr = 1'b1;
                  end else begin
                     state_nxt     = ST_VBLANK;
                     blank_cnt_nxt = '0;
                  end
               end else if (col_last && (HBLANK != 0)) begin
                  state_nxt     = ST_HBLANK;
                  blank_cnt_nxt = '0;
               end
            end
         end
         ST_HBLANK: begin
            if (blank_cnt == HB_LAST)
               state_nxt = ST_LINE;
            else
               blank_cnt_nxt = blank_cnt + 1'b1;
         end
         ST_VBLANK: begin
            if (blank_cnt == VB_LAST) begin
               state_nxt = ST_LINE;
               op_ld     = 1'b1;
               pos_clr   = 1'b1;
            end else begin
               blank_cnt_nxt = blank_cnt + 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // Abort overrides everything, including a same-cycle start or frame end.
      if (abort) begin
         state_nxt     = ST_IDLE;
         blank_cnt_nxt = '0;
         pos_en        = 1'b0;
         pos_clr       = 1'b1;
         op_ld         = 1'b0;
         run_ld        = 1'b0;
         frame_inc     = 1'b0;
         done_nxt      = 1'b0;
      end
   end

endmodule

// File: tb/tb_img_frame_sequencer.sv
// Scoreboard bench for img_frame_sequencer: directed timelines plus randomized runs against a raster model.
module tb_img_frame_sequencer;

   localparam int W    = 4;
   localparam int H    = 3;
   localparam int HB   = 2;
   localparam int VB   = 3;
   localparam int AW   = 4;
   localparam int NPIX = W * H;
   localparam int MAXC = 64;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          sof;
      logic          eol;
      logic          eof;
      logic [1:0]    op;
   } px_t;

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic          start, abort, out_ready;
   logic [7:0]    num_frames;
   logic [1:0]    op_sel_in;
   logic [AW-1:0] rd_addr;
   logic          pix_valid, HSYNC, VSYNC, sof, eol, eof, busy, frame_done;
   logic [1:0]    op_sel;
   logic [7:0]    frame_cnt;

   px_t        px_q[$];
   logic [7:0] fd_q[$];
   bit         mon_en;
   int         total = 0;
   int         bad   = 0;

   img_frame_sequencer #(
      .WIDTH(W), .HEIGHT(H), .HBLANK(HB), .VBLANK(VB), .ADDR_W(AW)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .abort(abort),
      .num_frames(num_frames), .op_sel_in(op_sel_in), .out_ready(out_ready),
      .rd_addr(rd_addr), .pix_valid(pix_valid), .HSYNC(HSYNC), .VSYNC(VSYNC),
      .sof(sof), .eol(eol), .eof(eof), .op_sel(op_sel), .busy(busy),
      .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic push_px(input int p, input logic [1:0] op);
      px_t e;
      e.addr = AW'(p);
      e.sof  = (p == 0);
      e.eol  = ((p % W) == W - 1);
      e.eof  = (p == NPIX - 1);
      e.op   = op;
      px_q.push_back(e);
   endtask

   task automatic push_frame(input logic [1:0] op, input logic [7:0] fc);
      for (int p = 0; p < NPIX; p++) push_px(p, op);
      fd_q.push_back(fc);
   endtask

   task automatic chk_reset_vals(input string name);
      chk(name, {10'd0, rd_addr, pix_valid, HSYNC, VSYNC, sof, eol, eof,
                 op_sel, busy, frame_done, frame_cnt}, 32'd0);
   endtask

   // Monitor: every handshake and every frame_done pops the next expectation.
   always @(negedge HCLK) begin
      if (mon_en && HRESETn) begin
         if (pix_valid && out_ready) begin
            if (px_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_pixel: DUT transferred addr %0d, nothing expected", rd_addr);
            end else begin
               px_t e;
               e = px_q.pop_front();
               chk("pixel", {20'd0, rd_addr, sof, eol, eof, HSYNC, VSYNC, busy, op_sel},
                            {20'd0, e.addr, e.sof, e.eol, e.eof, 3'b111, e.op});
            end
         end
         if (frame_done) begin
            if (fd_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_frame_done: DUT frame_cnt %0d, nothing expected", frame_cnt);
            end else begin
               chk("frame_done_cnt", {24'd0, frame_cnt}, {24'd0, fd_q.pop_front()});
            end
         end
      end
   end

   // Cycle-exact run: model builds the expected timeline from the raster rules,
   // with an optional out_ready stall window [s, s+n) and an optional abort cycle a.
   task automatic run_timed(input string tag, input logic [7:0] nf,
                            input int s, input int n, input int a);
      bit         pv [MAXC];
      bit         vb [MAXC];
      bit         dn [MAXC];
      int         ad [MAXC];
      int         c, end_c, ndone;
      logic [1:0] op;
      bit         live, e_pv, e_dn;
      logic [AW-1:0] act_addr;
      for (int i = 0; i < MAXC; i++) begin
         pv[i] = 0; vb[i] = 0; dn[i] = 0; ad[i] = 0;
      end
      op    = 2'($urandom);
      c     = 1;
      ndone = 0;
      for (int f = 0; f < int'(nf); f++) begin
         for (int p = 0; p < NPIX; p++) begin
            while (c >= s && c < s + n) begin
               pv[c] = 1; ad[c] = p; c++;
            end
            pv[c] = 1; ad[c] = p;
            if (a < 0 || c <= a) push_px(p, op);
            c++;
            if ((p % W) == W - 1) begin
               if (p / W < H - 1) begin
                  c += HB;
               end else begin
                  dn[c] = 1;
                  if (a < 0 || c <= a) begin
                     ndone++;
                     fd_q.push_back(8'(ndone));
                  end
                  if (f < int'(nf) - 1) begin
                     for (int k = 0; k < VB; k++) vb[c + k] = 1;
                     c += VB;
                  end
               end
            end
         end
      end
      end_c = c;
      for (int cc = 0; cc <= end_c + 2; cc++) begin
         start      = (cc == 0);
         abort      = (cc == a);
         out_ready  = !(cc >= s && cc < s + n);
         num_frames = (cc == 0) ? nf : 8'($urandom);
         op_sel_in  = op;
         @(negedge HCLK);
         live     = (cc >= 1) && (cc < end_c) && (a < 0 || cc <= a);
         e_pv     = live && pv[cc];
         e_dn     = dn[cc] && (a < 0 || cc <= a);
         act_addr = (e_pv || !live) ? rd_addr : '0;
         chk({tag, "_timeline"},
             {23'd0, pix_valid, HSYNC, VSYNC, busy, frame_done, act_addr},
             {23'd0, e_pv, e_pv, live && !vb[cc], live, e_dn, e_pv ? AW'(ad[cc]) : AW'(0)});
         tick();
      end
      start = 0; abort = 0; out_ready = 1;
      chk({tag, "_frame_cnt"}, {24'd0, frame_cnt}, ndone);
      chk({tag, "_op_sel"}, {30'd0, op_sel}, {30'd0, op});
      chk({tag, "_drained"}, px_q.size() + fd_q.size(), 0);
   endtask

   // Randomized run: expectations for frame k+1 are queued when frame k's first pixel
   // is seen, together with the op select chosen for it. nf=0 runs are aborted in
   // the blanking after frame total_fr.
   task automatic run_rand(input logic [7:0] nf, input int total_fr, input int rdy_pct,
                           input int op0, input int op1);
      logic [1:0] op;
      int  sofs = 0, dones = 0, vbc = 0, exp_vbc;
      bit  go_abort = 0, aborted = 0, done_run = 0, ok_poke;
      op         = (op0 < 0) ? 2'($urandom) : 2'(op0);
      op_sel_in  = op;
      num_frames = nf;
      out_ready  = 1;
      abort      = 0;
      start      = 1;
      push_frame(op, 8'd1);
      tick();
      start = 0;
      for (int cyc = 0; cyc < 20000 && !done_run; cyc++) begin
         @(negedge HCLK);
         ok_poke = 0;
         if (!busy) begin
            done_run = 1;
         end else begin
            if (sof && out_ready) begin
               sofs++;
               if (sofs < total_fr) begin
                  op = (op1 >= 0 && sofs == 1) ? 2'(op1) : 2'($urandom);
                  push_frame(op, 8'(sofs + 1));
               end
            end
            if (frame_done) dones++;
            if (!VSYNC) vbc++;
            if (nf == 8'd0 && dones == total_fr) go_abort = 1;
            ok_poke = !(eof && out_ready) && !go_abort;
         end
         tick();
         op_sel_in  = op;
         num_frames = 8'($urandom);
         out_ready  = ($urandom_range(0, 99) < rdy_pct);
         start      = ok_poke && ($urandom_range(0, 7) == 0);
         abort      = go_abort && !aborted;
         if (abort) aborted = 1;
      end
      start = 0; abort = 0; out_ready = 1;
      tick();
      exp_vbc = (total_fr - 1) * VB + ((nf == 8'd0) ? 2 : 0);
      chk("rand_completed", done_run, 1);
      chk("rand_vblank_cycles", vbc, exp_vbc);
      chk("rand_frame_cnt", {24'd0, frame_cnt}, {24'd0, 8'(total_fr)});
      chk("rand_op_sel", {30'd0, op_sel}, {30'd0, op});
      chk("rand_idle", {26'd0, busy, pix_valid, rd_addr}, 32'd0);
      chk("rand_drained", px_q.size() + fd_q.size(), 0);
   endtask

   initial begin
      logic [7:0] nfr;
      HRESETn = 0; start = 0; abort = 0; out_ready = 1;
      num_frames = 0; op_sel_in = 0; mon_en = 0;
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      chk_reset_vals("reset_init");
      tick();
      HRESETn = 1;
      mon_en  = 1;
      tick();

      run_timed("basic",   8'd1, -1, 0, -1);
      run_timed("stall",   8'd1,  8, 3, -1);
      run_timed("abort",   8'd2, -1, 0, 28);
      run_timed("restart", 8'd1, -1, 0, -1);

      start = 1; abort = 1;
      tick();
      start = 0; abort = 0;
      repeat (3) begin
         @(negedge HCLK);
         chk("start_abort_idle", {29'd0, busy, pix_valid, VSYNC}, 32'd0);
         tick();
      end

      run_rand(8'd2, 2, 100, 0, 2);
      repeat (6) begin
         nfr = 8'($urandom_range(1, 3));
         run_rand(nfr, int'(nfr), 70, -1, -1);
      end
      run_rand(8'd0, 257, 100, -1, -1);

      mon_en = 0;
      num_frames = 8'd3; op_sel_in = 2'd3; start = 1;
      tick();
      start = 0;
      repeat (24) tick();
      HRESETn = 0;
      @(negedge HCLK);
      chk_reset_vals("reset_midrun");
      px_q.delete();
      fd_q.delete();
      tick();
      HRESETn = 1;
      repeat (4) begin
         @(negedge HCLK);
         chk_reset_vals("post_reset_idle");
         tick();
      end
      mon_en = 1;
      run_timed("after_reset", 8'd1, 5, 2, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
